// File: rtl/jpeg_byte_stuffer.sv
// JPEG byte stuffer: serialises packed entropy-coded words byte 0 first and inserts 0x00 after every 0xFF.
// Defining JPEG_STUFFER_EOI_EN appends the 0xFF 0xD9 end-of-image marker after every in_last word.
module jpeg_byte_stuffer #(
  parameter int BYTES_IN = 4,
  parameter int CNT_W    = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [8*BYTES_IN-1:0]         in_data,
  input  logic [$clog2(BYTES_IN+1)-1:0] in_nbytes,
  input  logic                          in_last,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CNT_W-1:0]              stuff_count,
  output logic                          scan_done
);

  localparam int NB_W = $clog2(BYTES_IN + 1);

`ifdef JPEG_STUFFER_EOI_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_STUFF  = 3'd2,
    ST_EOI_FF = 3'd3,
    ST_EOI_D9 = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_STUFF = 2'd2
  } state_t;
`endif

  state_t                state_r, state_s;
  logic [8*BYTES_IN-1:0] word_r, word_s;
  logic [NB_W-1:0]       nbytes_r, idx_r, idx_s;
  logic                  last_r;
  logic [7:0]            out_data_r, out_data_s;
  logic                  out_valid_r, out_valid_s;
  logic [CNT_W-1:0]      stuff_count_r;
  logic                  scan_done_r, scan_done_s;
  logic                  in_ready_s, accept_s, load_s;
  logic                  word_end_s, eos_s, stuff_inc_s;
  logic                  xfer_s, last_byte_s;
  logic [7:0]            cur_byte_s;

  function automatic logic [7:0] select_byte(input logic [8*BYTES_IN-1:0] w,
                                             input logic [NB_W-1:0]       i);
    logic [7:0] b;
    b = 8'h00;
    for (int k = 0; k < BYTES_IN; k++) begin
      if (i == NB_W'(k)) begin
        b = w[8*k +: 8];
      end
    end
    return b;
  endfunction

  assign xfer_s      = out_valid_r & out_ready;
  assign cur_byte_s  = select_byte(word_r, idx_r);
  assign last_byte_s = (idx_r == (nbytes_r - NB_W'(1)));

  // Next-state, handshake and counter-enable decisions
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    in_ready_s  = 1'b0;
    stuff_inc_s = 1'b0;
    word_end_s  = 1'b0;
    eos_s       = 1'b0;
    scan_done_s = 1'b0;
    load_s      = 1'b0;
    accept_s    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        in_ready_s = 1'b1;
      end
      ST_DATA: begin
        if (xfer_s) begin
          if (cur_byte_s == 8'hFF) begin
            state_s = ST_STUFF;
          end else if (!last_byte_s) begin
            idx_s = idx_r + NB_W'(1);
          end else begin
            word_end_s = 1'b1;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_STUFF: begin
        if (xfer_s) begin
          stuff_inc_s = 1'b1;
          if (!last_byte_s) begin
            idx_s   = idx_r + NB_W'(1);
            state_s = ST_DATA;
          end else begin
            word_end_s = 1'b1;
          end
        end else begin
          state_s = ST_STUFF;
        end
      end
`ifdef JPEG_STUFFER_EOI_EN
      ST_EOI_FF: begin
        if (xfer_s) begin
          state_s = ST_EOI_D9;
        end else begin
          state_s = ST_EOI_FF;
        end
      end
      ST_EOI_D9: begin
        if (xfer_s) begin
          state_s     = ST_IDLE;
          scan_done_s = 1'b1;
        end else begin
          state_s = ST_EOI_D9;
        end
      end
`endif
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // A finishing non-last word reopens the input in the same cycle so the next word follows without a bubble.
    if (word_end_s) begin
      state_s = ST_IDLE;
      if (last_r) begin
        eos_s = 1'b1;
      end else begin
        in_ready_s = 1'b1;
      end
    end else begin
      eos_s = 1'b0;
    end

    accept_s = in_ready_s & in_valid;

    if (accept_s && (in_nbytes != '0)) begin
      load_s  = 1'b1;
      idx_s   = '0;
      state_s = ST_DATA;
    end else if (eos_s || (accept_s && in_last)) begin
`ifdef JPEG_STUFFER_EOI_EN
      state_s = ST_EOI_FF;
`else
      state_s     = ST_IDLE;
      scan_done_s = 1'b1;
`endif
    end else begin
      load_s = 1'b0;
    end
  end

  assign word_s      = load_s ? in_data : word_r;
  assign out_valid_s = (state_s != ST_IDLE);

  // Byte presented in the state being entered; registered so outputs hold steady under back-pressure
  always_comb begin
    out_data_s = 8'h00;
    case (state_s)
      ST_DATA:   out_data_s = select_byte(word_s, idx_s);
      ST_STUFF:  out_data_s = 8'h00;
`ifdef JPEG_STUFFER_EOI_EN
      ST_EOI_FF: out_data_s = 8'hFF;
      ST_EOI_D9: out_data_s = 8'hD9;
`endif
      default:   out_data_s = 8'h00;
    endcase
  end

  // State, held word and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      word_r        <= '0;
      nbytes_r      <= '0;
      last_r        <= 1'b0;
      idx_r         <= '0;
      out_data_r    <= 8'h00;
      out_valid_r   <= 1'b0;
      stuff_count_r <= '0;
      scan_done_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      word_r      <= word_s;
      idx_r       <= idx_s;
      out_data_r  <= out_data_s;
      out_valid_r <= out_valid_s;
      scan_done_r <= scan_done_s;
      if (load_s) begin
        nbytes_r <= in_nbytes;
        last_r   <= in_last;
      end else begin
        nbytes_r <= nbytes_r;
        last_r   <= last_r;
      end
      if (stuff_inc_s) begin
        stuff_count_r <= stuff_count_r + CNT_W'(1);
      end else begin
        stuff_count_r <= stuff_count_r;
      end
    end
  end

  assign in_ready    = in_ready_s;
  assign out_data    = out_data_r;
  assign out_valid   = out_valid_r;
  assign stuff_count = stuff_count_r;
  assign scan_done   = scan_done_r;

endmodule

// File: tb/tb_jpeg_byte_stuffer.sv
// Directed bench for jpeg_byte_stuffer: vector table plus hand-written handshake, reset and wrap sequences.
module tb_jpeg_byte_stuffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [2:0]  in_nbytes;
  logic        in_last, in_valid, out_ready;
  logic        in_ready, out_valid, scan_done;
  logic [7:0]  out_data;
  logic [15:0] stuff_count;
  logic        in_ready4, out_valid4, scan_done4;
  logic [7:0]  out_data4;
  logic [3:0]  stuff_count4;

  always #5 clk = ~clk;

  jpeg_byte_stuffer #(.BYTES_IN(4), .CNT_W(16)) dut (
    .clock(clk), .reset(rst), .in_data(in_data), .in_nbytes(in_nbytes), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .stuff_count(stuff_count), .scan_done(scan_done));

  // Narrow-counter copy sharing the same stimulus, used for the wrap check
  jpeg_byte_stuffer #(.BYTES_IN(4), .CNT_W(4)) dut4 (
    .clock(clk), .reset(rst), .in_data(in_data), .in_nbytes(in_nbytes), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready4), .out_data(out_data4), .out_valid(out_valid4),
    .out_ready(out_ready), .stuff_count(stuff_count4), .scan_done(scan_done4));

  typedef struct {
    logic [31:0] data;
    logic [2:0]  nb;
    logic [79:0] exp;   // expected bytes, first byte in the top octet
    int          n;
    int          dstuff;
  } vec_t;

  vec_t        vecs [7];
  logic [31:0] b2b [3] = '{32'h03020100, 32'h07060504, 32'h0B0A0908};

  int checks = 0, passes = 0, fails = 0;
  int cyc = 0, scan_pulses = 0, rwv = 0, stalls = 0, exp_cnt = 0;
  logic [7:0] got [$];
  int         stamp [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_bytes(input string name, input logic [79:0] exp, input int n);
    chk({name, "_count"}, got.size(), n);
    for (int j = 0; j < n && j < got.size(); j++)
      chk($sformatf("%s_b%0d", name, j), got[j], exp[79-8*j -: 8]);
  endtask

  task automatic send(input logic [31:0] d, input logic [2:0] nb, input logic last);
    bit ok = 1'b0;
    in_data = d; in_nbytes = nb; in_last = last; in_valid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("send_accepted", ok, 1);
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (!out_valid && in_ready) begin ok = 1'b1; break; end
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain_done", ok, 1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: collects transferred bytes and checks stability across stalls
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (prev_stall) stalls++;
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        stamp.push_back(cyc);
      end
      if (scan_done) scan_pulses++;
      if (out_valid && in_ready) rwv++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit         ok;
    int         first_acc, s0, r0, st0;
    logic [79:0] exp_last, exp_nb0;
    int         n_last, n_nb0;

    vecs[0] = '{32'h12FF3400, 3'd4, {8'h00, 8'h34, 8'hFF, 8'h00, 8'h12, 40'h0}, 5, 1};
    vecs[1] = '{32'h00000000, 3'd4, {8'h00, 8'h00, 8'h00, 8'h00, 48'h0}, 4, 0};
    vecs[2] = '{32'hAABBCCDD, 3'd2, {8'hDD, 8'hCC, 64'h0}, 2, 0};
    vecs[3] = '{32'h000000FF, 3'd1, {8'hFF, 8'h00, 64'h0}, 2, 1};
    vecs[4] = '{32'hFF0000FE, 3'd3, {8'hFE, 8'h00, 8'h00, 56'h0}, 3, 0};
    vecs[5] = '{32'h11223344, 3'd0, 80'h0, 0, 0};
    vecs[6] = '{32'hFFFFFF7F, 3'd4, {8'h7F, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 24'h0}, 7, 3};
`ifdef JPEG_STUFFER_EOI_EN
    exp_last = {8'h01, 8'hAB, 8'hFF, 8'hD9, 48'h0}; n_last = 4;
    exp_nb0  = {8'hFF, 8'hD9, 64'h0};               n_nb0  = 2;
`else
    exp_last = {8'h01, 8'hAB, 64'h0};               n_last = 2;
    exp_nb0  = 80'h0;                               n_nb0  = 0;
`endif

    rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; in_nbytes = 3'd0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_stuff_count", stuff_count, 0);
    chk("rst_scan_done", scan_done, 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      got.delete(); stamp.delete();
      send(vecs[i].data, vecs[i].nb, 1'b0);
      drain();
      exp_cnt += vecs[i].dstuff;
      chk_bytes($sformatf("vec%0d", i), vecs[i].exp, vecs[i].n);
      chk($sformatf("vec%0d_stuff", i), stuff_count, exp_cnt & 32'hFFFF);
    end
    chk("no_scan_done_nonlast", scan_pulses, 0);

    // Back-to-back words with out_ready held high: one byte per cycle, no bubble at word boundaries
    got.delete(); stamp.delete();
    in_valid = 1'b1; in_last = 1'b0; in_nbytes = 3'd4; first_acc = 0;
    for (int w = 0; w < 3; w++) begin
      in_data = b2b[w];
      ok = 1'b0;
      for (int t = 0; t < 50; t++) begin
        @(negedge clk);
        if (in_ready) begin ok = 1'b1; break; end
      end
      if (w == 0) first_acc = cyc;
      @(posedge clk); #1;
      chk($sformatf("b2b_accept%0d", w), ok, 1);
    end
    in_valid = 1'b0;
    drain();
    chk("b2b_count", got.size(), 12);
    if (stamp.size() > 0) chk("b2b_first_latency", stamp[0], first_acc + 1);
    for (int j = 0; j < 12 && j < got.size(); j++) begin
      chk($sformatf("b2b_b%0d", j), got[j], j);
      chk($sformatf("b2b_cycle%0d", j), stamp[j], stamp[0] + j);
    end

    // All-0xFF word under alternating back-pressure
    got.delete(); stamp.delete();
    send(32'hFFFFFFFF, 3'd4, 1'b0);
    st0 = stalls;
    for (int t = 0; t < 40; t++) begin
      out_ready = (t % 2 == 0);
      @(posedge clk); #1;
      if (got.size() >= 8 && !out_valid) break;
    end
    out_ready = 1'b1;
    drain();
    exp_cnt += 4;
    chk_bytes("ff4", {8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 16'h0}, 8);
    chk("ff4_stalls", stalls - st0, 7);
    chk("ff4_stuff", stuff_count, exp_cnt & 32'hFFFF);

    // Final word of a scan
    got.delete(); stamp.delete();
    s0 = scan_pulses; r0 = rwv;
    send(32'h0000AB01, 3'd2, 1'b1);
    drain();
    chk_bytes("last", exp_last, n_last);
    chk("last_scan_pulse", scan_pulses - s0, 1);
    chk("last_no_ready_while_busy", rwv - r0, 0);
    chk("last_in_ready_after", in_ready, 1);
    chk("last_stuff", stuff_count, exp_cnt & 32'hFFFF);

    // Empty last word ends the scan immediately
    got.delete(); stamp.delete();
    s0 = scan_pulses;
    send(32'h12345678, 3'd0, 1'b1);
    drain();
    chk_bytes("empty_last", exp_nb0, n_nb0);
    chk("empty_last_scan_pulse", scan_pulses - s0, 1);

    // Reset asserted after two of four bytes
    got.delete(); stamp.delete();
    send(32'h44332211, 3'd4, 1'b0);
    for (int t = 0; t < 20; t++) begin
      if (got.size() >= 2) break;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_stuff", stuff_count, 0);
    chk("midrst_stuff4", stuff_count4, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_bytes("midrst_partial", {8'h11, 8'h22, 64'h0}, 2);
    got.delete(); stamp.delete();
    send(32'h0000BEEF, 3'd2, 1'b0);
    drain();
    chk_bytes("after_rst", {8'hEF, 8'hBE, 64'h0}, 2);

    // Seventeen stuffed bytes: narrow counter wraps to 1
    for (int w = 0; w < 4; w++) begin
      send(32'hFFFFFFFF, 3'd4, 1'b0);
      drain();
    end
    got.delete(); stamp.delete();
    send(32'h000000FF, 3'd1, 1'b0);
    drain();
    exp_cnt += 17;
    chk_bytes("wrap_tail", {8'hFF, 8'h00, 64'h0}, 2);
    chk("wrap_stuff16", stuff_count, exp_cnt & 32'hFFFF);
    chk("wrap_stuff4", stuff_count4, exp_cnt & 32'hF);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/jpeg_byte_stuffer.md
JPEG_BYTE_STUFFER -- requirements
Module: jpeg_byte_stuffer

Interface
REQ-001 SHALL: parameter BYTES_IN, default 4, number of bytes per input word (legal 1..8).
REQ-002 SHALL: parameter CNT_W, default 16, width of the stuffed-byte counter.
REQ-003 SHALL: clock  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL: reset  input  1  asynchronous, active-high; clears all state.
REQ-005 SHALL: in_data  input  8*BYTES_IN  packed entropy-coded word; byte k = bits [8k+7:8k].
REQ-006 SHALL: in_nbytes  input  $clog2(BYTES_IN+1)  count of valid bytes in in_data, from byte 0 upward.
REQ-007 SHALL: in_last  input  1  marks the final word of a scan.
REQ-008 SHALL: in_valid / in_ready  input / output  1 / 1  input handshake; transfer when both are high.
REQ-009 SHALL: out_data  output  8  stuffed byte stream.
REQ-010 SHALL: out_valid / out_ready  output / input  1 / 1  output handshake; transfer when both are high.
REQ-011 SHALL: stuff_count  output  CNT_W  number of 0x00 stuff bytes emitted since reset.
REQ-012 SHALL: scan_done  output  1  one-cycle pulse after the final byte of an in_last word is transferred.

Function
REQ-013 SHALL: states are IDLE, DATA, STUFF, EOI_FF, EOI_D9.
REQ-014 SHALL: IDLE: in_ready=1, out_valid=0; on accept with in_nbytes>0, latch word, nbytes and last; byte index=0; go to DATA.
REQ-015 SHALL: accepted word with in_nbytes=0: discarded; if in_last, treated as an immediate end of scan (EOI or scan_done per REQ-022/023).
REQ-016 SHALL: DATA: out_valid=1, out_data=held byte[index]; bytes emitted LSB byte first (byte 0 first).
REQ-017 SHALL: DATA transfer of byte 0xFF -> STUFF; STUFF: out_data=0x00, out_valid=1; on transfer, stuff_count+1 (wraps modulo 2^CNT_W), then continue with next byte.
REQ-018 SHALL: non-0xFF bytes are never followed by 0x00; 0x00 bytes pass unchanged.
REQ-019 SHALL: in_ready SHALL also be high in DATA or STUFF when the final byte (or its stuff byte) of a non-last word is transferring this cycle; a word accepted then is latched and DATA continues at index 0 with no bubble.
REQ-020 SHALL: with out_ready held high and no stuffing, sustained throughput = 1 byte/cycle; first byte of a word accepted in IDLE appears on out_data the cycle after acceptance.
REQ-021 SHALL: out_data and out_valid are held stable while out_valid=1 and out_ready=0.
REQ-022 SHALL: end of an in_last word (last byte and any stuff byte transferred): if JPEG_STUFFER_EOI_EN defined -> EOI_FF; otherwise -> IDLE with scan_done=1 the next cycle.
REQ-023 SHALL: EOI_FF emits 0xFF, then EOI_D9 emits 0xD9; neither is stuffed or counted; after the 0xD9 transfer -> IDLE, scan_done=1 for one cycle.
REQ-024 SHALL: in_ready=0 in EOI_FF and EOI_D9, and after the last byte of an in_last word.
REQ-025 SHALL: in_valid while in_ready=0 is ignored; the producer holds the word.

Reset
REQ-026 SHALL: on reset: state=IDLE, in_ready=1 after release, out_valid=0, out_data=0x00, stuff_count=0, scan_done=0, held word discarded.
REQ-027 SHALL: reset asserted mid-word or mid-EOI aborts immediately; no further bytes of that word are emitted.

Configuration
REQ-028 SHALL: macro JPEG_STUFFER_EOI_EN defined -> EOI_FF/EOI_D9 states present and 0xFF 0xD9 is appended after every in_last word; undefined -> those states are not compiled, and in_last only produces scan_done.

Verification
REQ-029 SHALL: BYTES_IN=4, word 0x12FF3400, nbytes=4, out_ready=1 -> out bytes 00,34,FF,00,12; stuff_count=1.
REQ-030 SHALL: BYTES_IN=4, three back-to-back words, no 0xFF, out_ready=1 -> 12 bytes on 12 consecutive cycles, in_ready never drops between words.
REQ-031 SHALL: word 0xFFFFFFFF, out_ready toggled 1,0,1,0 -> 8 bytes FF,00 x4 in order, out_data stable during stalls, stuff_count=4.
REQ-032 SHALL: EOI_EN defined, word 0x0000AB01 nbytes=2 in_last=1 -> 01,AB,FF,D9, then scan_done pulse, in_ready=1; undefined -> 01,AB, then scan_done.
REQ-033 SHALL: reset asserted after 2 of 4 bytes emitted -> out_valid=0 immediately, stuff_count=0; next word emits from its byte 0.
REQ-034 SHALL: CNT_W=4, 17 stuffed 0xFF bytes -> stuff_count=1 (wrap).
